des_key_sched_iter: RTL

- Iterative DES round-key scheduler; the sequential counterpart of the flat combinational 16-key generator.
- Emits one 48-bit round key per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key register and an iterative or pipelined DES round datapath.
- Decrypt order comes from right rotations, so no 768-bit key bus is needed.

---
 rtl/des_key_sched_iter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/des_key_sched_iter.sv
// Iterative DES round-key scheduler: loads PC1(key) on start, then emits one
// PC2 round key per valid/ready handshake in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched_iter #(
    parameter int KEY_W      = 64,
    parameter int RK_W       = 48,
    parameter int NUM_ROUNDS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             decrypt,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_ready,
    output logic             key_valid,
    output logic [RK_W-1:0]  round_key,
    output logic [3:0]       round_idx,
    output logic             last,
    output logic             busy
);

    // Handshake: a key transfers on a rising edge where key_valid && key_ready;
    // round_key/round_idx/last are held stable while key_valid && !key_ready.

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Table entries use DES numbering: bit 1 is the MSB of the vector.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return r;
    endfunction

    // Encrypt rounds 1, 2, 9 and 16 shift by one; every other round by two.
    function automatic logic shift_two(input int r);
        return !(r == 1 || r == 2 || r == 9 || r == 16);
    endfunction

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [3:0]  cnt_q;
    logic        mode_q;
    logic        load;
    logic        advance;
    logic        final_cnt;
    logic [55:0] pc1_key;
    logic        two_enc;
    logic        two_dec;

    assign pc1_key   = pc1(key_in);
    assign final_cnt = (cnt_q == 4'(NUM_ROUNDS - 1));
    assign two_enc   = shift_two(int'(cnt_q) + 2);
    assign two_dec   = shift_two(16 - int'(cnt_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = GEN;
                end
            end
            GEN: begin
                if (key_ready) begin
                    if (final_cnt) begin
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Encrypt pre-applies round 1's shift at load; decrypt starts from C0/D0 == C16/D16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            mode_q <= decrypt;
            cnt_q  <= '0;
            c_q    <= decrypt ? pc1_key[55:28] : rot_l(pc1_key[55:28], 1'b0);
            d_q    <= decrypt ? pc1_key[27:0]  : rot_l(pc1_key[27:0], 1'b0);
        end else if (advance) begin
            cnt_q <= cnt_q + 4'd1;
            c_q   <= mode_q ? rot_r(c_q, two_dec) : rot_l(c_q, two_enc);
            d_q   <= mode_q ? rot_r(d_q, two_dec) : rot_l(d_q, two_enc);
        end
    end

    assign key_valid = (state == GEN);
    assign busy      = key_valid;
    assign last      = key_valid && final_cnt;
    assign round_idx = key_valid ? cnt_q : 4'd0;
    assign round_key = key_valid ? pc2({c_q, d_q}) : '0;

endmodule
